// File: rtl/mdu_sequencer.sv
// Iterative RV32M sequencer: shift-add multiply and restoring divide, one
// bit per cycle. The pipeline is stalled while the operation runs and the
// result is presented for exactly one DONE cycle.
//
// Handshake: an operation is accepted on a rising edge where state is IDLE,
// start_i=1 and flush_i=0; operands and funct3 are sampled only on that edge.
// done_o=1 for one cycle marks result_o valid; result_o holds otherwise.
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mb_q, mb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode at the accept edge: signedness, magnitudes, result sign.
  logic            a_signed, b_signed, sa, sb, acc_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div0, ovf, special;
  logic [XLEN-1:0] special_res;

  // Decode signedness and the short-circuit cases from the incoming op.
  always_comb begin
    a_signed    = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                  (funct3_i == 3'd4) || (funct3_i == 3'd6);
    b_signed    = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    sa          = a_signed & op_a_i[XLEN-1];
    sb          = b_signed & op_b_i[XLEN-1];
    mag_a       = sa ? -op_a_i : op_a_i;
    mag_b       = sb ? -op_b_i : op_b_i;
    // Remainder follows the dividend; everything else is sa^sb.
    acc_neg     = (funct3_i == 3'd6) ? sa : (sa ^ sb);
    div0        = funct3_i[2] && (op_b_i == '0);
    ovf         = funct3_i[2] && !funct3_i[0] && (op_a_i == INT_MIN) && (op_b_i == '1);
    special     = div0 || ovf;
    if (div0) special_res = funct3_i[1] ? op_a_i : '1;
    else      special_res = funct3_i[1] ? '0 : INT_MIN;
  end

  // One iteration step for each datapath, plus the final sign/half selection.
  logic [XLEN:0]     mul_sum, div_top, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_step, div_step, mul_full;
  logic [XLEN-1:0]   quo, rem, fix_res;

  // Datapath arithmetic for CALC and FIX.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mb_q : {XLEN{1'b0}})};
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    div_top  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_top - {1'b0, mb_q};
    div_ge   = ~div_diff[XLEN];
    div_step = {(div_ge ? div_diff[XLEN-1:0] : div_top[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    mul_full = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'd0:          fix_res = mul_full[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          fix_res = mul_full[2*XLEN-1:XLEN];
      3'd4, 3'd5:    fix_res = quo;
      default:       fix_res = rem;
    endcase
  end

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          f3_d  = funct3_i;
          neg_d = acc_neg;
          mb_d  = mag_b;
          acc_d = {{XLEN{1'b0}}, mag_a};
          if (special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = f3_q[2] ? div_step : mul_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      mb_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Outputs; stall is forced low while reset is asserted.
  assign stall_o  = ~rst & ((start_i & (state_q == S_IDLE)) |
                            (state_q == S_CALC) | (state_q == S_FIX));
  assign busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed vector table, multi-cycle corner
// sequences (flush, async reset, back-to-back) and randomized ops against
// an arithmetic reference model.
module tb_mdu_sequencer;

  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        stall, busy, done;
  logic [31:0] result;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .funct3_i(f3),
    .op_a_i(a), .op_b_i(b), .flush_i(flush),
    .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV32M arithmetic rules.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy, p;
    logic [63:0] pv;
    logic [31:0] r;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = 32'd0;
    case (op)
      3'd0: begin p = ux * uy; pv = p; r = pv[31:0]; end
      3'd1: begin p = sx * sy; pv = p; r = pv[63:32]; end
      3'd2: begin p = sx * uy; pv = p; r = pv[63:32]; end
      3'd3: begin pv = {32'd0, x} * {32'd0, y}; r = pv[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == MINV && y == 32'hFFFF_FFFF) r = MINV;
        else r = $signed(x) / $signed(y);
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == MINV && y == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(x) % $signed(y);
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op[2] && (y == 0 || (!op[0] && x == MINV && y == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  // Driver: issue one op with start held until done; scramble inputs after
  // accept. Returns result, edges-to-done (-1 on timeout), stall-high
  // samples and whether done_o dropped on the following cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int stalls,
                        output logic fell);
    int n;
    logic seen;
    @(negedge clk);
    start = 1'b1; f3 = op; a = x; b = y;
    #1;
    stalls = stall ? 1 : 0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (stall) stalls++;
      if (done) seen = 1'b1;
      else if (n == 1) begin
        a  = $urandom;
        b  = $urandom;
        f3 = 3'($urandom_range(0, 7));
      end
    end
    res = result;
    lat = seen ? n : -1;
    start = 1'b0;
    @(posedge clk); #1;
    fell = !done;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] res;
    int          lat, stalls, cnt, e1, e2;
    logic        fell;
    logic [31:0] pick[6];

    vecs[0]  = '{3'd5, 32'd100,       32'd7,        32'd14,         34, "divu_100_7"};
    vecs[1]  = '{3'd7, 32'd100,       32'd7,        32'd2,          34, "remu_100_7"};
    vecs[2]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF,  34, "rem_m7_2"};
    vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD,  34, "div_m7_2"};
    vecs[4]  = '{3'd4, 32'd5,         32'd0,        32'hFFFF_FFFF,  1,  "div_by0"};
    vecs[5]  = '{3'd7, 32'd5,         32'd0,        32'd5,          1,  "remu_by0"};
    vecs[6]  = '{3'd4, MINV,          32'hFFFF_FFFF, MINV,          1,  "div_ovf"};
    vecs[7]  = '{3'd6, MINV,          32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf"};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,        32'hFFFF_FFFF,  1,  "divu_by0"};
    vecs[9]  = '{3'd6, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9,  1,  "rem_by0"};
    vecs[10] = '{3'd5, MINV,          32'hFFFF_FFFF, 32'd0,         34, "divu_nospecial"};
    vecs[11] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ff"};
    vecs[12] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         34, "mulh_ff"};
    vecs[13] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu_ff"};
    vecs[14] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         34, "mul_ff"};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(vecs[i].exp);
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, stalls, fell);
      check({vecs[i].name, "_res"}, res, exp_q.pop_front());
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_stall"}, 32'(stalls), 32'(vecs[i].lat));
      check({vecs[i].name, "_pulse"}, {31'd0, fell}, 32'd1);
    end

    // Flush in CALC: no done, result holds the previous value.
    run_op(3'd0, 32'd7, 32'd6, res, lat, stalls, fell);
    check("pre_flush_mul", res, 32'd42);
    @(negedge clk);
    start = 1'b1; f3 = 3'd0; a = 32'd100; b = 32'd100;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result", result, 32'd42);
    flush = 1'b0;
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done) cnt++; end
    check("flush_no_done", 32'(cnt), 32'd0);
    check("flush_result_held", result, 32'd42);
    run_op(3'd0, 32'd3, 32'd4, res, lat, stalls, fell);
    check("post_flush_mul", res, 32'd12);
    check("post_flush_lat", 32'(lat), 32'd34);

    // Flush beats start in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; f3 = 3'd5; a = 32'd9; b = 32'd2;
    repeat (3) begin @(posedge clk); #1; end
    check("idle_flush_busy", {31'd0, busy}, 32'd0);
    check("idle_flush_done", {31'd0, done}, 32'd0);
    start = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; f3 = 3'd0; a = 32'd3; b = 32'd5;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1; start = 1'b0;
    #1;
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back DIVU with start held.
    @(negedge clk);
    start = 1'b1; f3 = 3'd5; a = 32'd100; b = 32'd7;
    cnt = 0; e1 = -1; e2 = -1;
    for (int n = 1; n <= 120 && cnt < 2; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (cnt == 0) e1 = n; else e2 = n;
        check($sformatf("b2b_res%0d", cnt), result, 32'd14);
        cnt++;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(cnt), 32'd2);
    check("b2b_first", 32'(e1), 32'd34);
    check("b2b_gap", 32'(e2 - e1), 32'd35);
    @(posedge clk); #1;

    // Randomized ops against the reference model.
    pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFF_FFFF;
    pick[3] = MINV;  pick[4] = 32'd7; pick[5] = 32'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      rf = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
      exp_q.push_back(ref_model(rf, ra, rb));
      run_op(rf, ra, rb, res, lat, stalls, fell);
      check($sformatf("rand%0d_f%0d_res", i, rf), res, exp_q.pop_front());
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(ref_lat(rf, ra, rb)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
